// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;
endpackage

// File: rtl/arbitro_rr_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface arbitro_rr_8_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [SEL_W-1:0]   sel;
  logic               grant_valid;
  logic [NUM_REQ-1:0] grant;
  logic               timeout;

  modport master (output req, input sel, grant_valid, grant, timeout);
  modport slave  (input req, output sel, grant_valid, grant, timeout);
endinterface

// File: rtl/decodificador_3bits.sv
// 3-to-8 one-hot decoder.
module decodificador_3bits (
  input  logic [2:0] en_i,
  output logic [7:0] dec_o
);
  always_comb begin
    dec_o = 8'b0000_0001 << en_i;
  end
endmodule

// File: rtl/arbitro_rr_8.sv
// Round-robin arbiter for 8 requesters with registered select and one-hot grant.
// Optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
module arbitro_rr_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input logic            clk,
  input logic            reset,
  arbitro_rr_8_if.slave  bus
);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               gv_q, gv_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               timeout_q, timeout_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SEL_W:0]     pick_s;
  logic [NUM_REQ-1:0] dec_s;

  // Scan last+1 .. last+7, then last itself, so the previous owner ranks lowest.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] res;
    logic             found;
    found = 1'b0;
    res   = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        res   = idx;
      end
    end
    return {found, res};
  endfunction

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gv_d      = gv_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    pick_s    = rr_pick(bus.req, sel_q);
    case (state_q)
      ST_IDLE: begin
        if (pick_s[SEL_W]) begin
          state_d = ST_BUSY;
          sel_d   = pick_s[SEL_W-1:0];
          gv_d    = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = hold_q;
        end
        if (!bus.req[sel_q]) begin
          state_d = ST_IDLE;
          gv_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = ST_IDLE;
          gv_d      = 1'b0;
          timeout_d = 1'b1;
`endif
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gv_d    = 1'b0;
      end
    endcase
  end

  // Grant is decoded from the next select so it can be registered alongside it.
  decodificador_3bits u_dec (
    .en_i  (sel_d),
    .dec_o (dec_s)
  );

  always_comb begin
    grant_d = dec_s & {NUM_REQ{gv_d}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_W'(NUM_REQ - 1);
      gv_q      <= 1'b0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gv_q      <= gv_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.grant_valid = gv_q;
  assign bus.grant       = grant_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_arbitro_rr_8.sv
// Directed self-checking bench for arbitro_rr_8 (DUT built with MAX_HOLD=4).
module tb_arbitro_rr_8;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [12:0] got;
  logic [12:0] exp;

  arbitro_rr_8_if bus();

  arbitro_rr_8 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs set after this are sampled next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
      exp = {3'd7, 1'b0, 8'h00, 1'b0};
      checks++;
      if (got !== exp) begin
        $display("FAIL reset_idle cyc%0d: got {sel,gv,grant,to}=%h expected %h", c, got, exp);
        errors++;
      end
    end
  endtask

  task automatic test_single();
    bus.req = 8'h08;
    for (int c = 0; c < 4; c++) begin
      tick();
      got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
      exp = {3'd3, 1'b1, 8'h08, 1'b0};
      checks++;
      if (got !== exp) begin
        $display("FAIL single_grant cyc%0d: got %h expected %h", c, got, exp);
        errors++;
      end
    end
    bus.req = 8'h00;
    for (int c = 0; c < 2; c++) begin
      tick();
      got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
      exp = {3'd3, 1'b0, 8'h00, 1'b0};
      checks++;
      if (got !== exp) begin
        $display("FAIL single_release cyc%0d: got %h expected %h", c, got, exp);
        errors++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] onehot;
    do_reset();
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      onehot = 8'h01 << (k % 8);
      for (int c = 0; c < 2; c++) begin
        tick();
        got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
        exp = {3'(k % 8), 1'b1, onehot, 1'b0};
        checks++;
        if (got !== exp) begin
          $display("FAIL rr_grant k%0d cyc%0d: got %h expected %h", k, c, got, exp);
          errors++;
        end
      end
      bus.req = 8'hFF & ~onehot;
      tick();
      got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
      exp = {3'(k % 8), 1'b0, 8'h00, 1'b0};
      checks++;
      if (got !== exp) begin
        $display("FAIL rr_dead_cycle k%0d: got %h expected %h", k, got, exp);
        errors++;
      end
      bus.req = 8'hFF;
    end
    bus.req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    bus.req = 8'h40;
    tick();
    bus.req = 8'h00;
    tick();
    got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
    exp = {3'd6, 1'b0, 8'h00, 1'b0};
    checks++;
    if (got !== exp) begin
      $display("FAIL wrap_setup: got %h expected %h", got, exp);
      errors++;
    end
    bus.req = 8'h41;
    tick();
    got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
    exp = {3'd0, 1'b1, 8'h01, 1'b0};
    checks++;
    if (got !== exp) begin
      $display("FAIL wrap_to_0: got %h expected %h", got, exp);
      errors++;
    end
    bus.req = 8'h40;
    tick();
    bus.req = 8'h41;
    tick();
    got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
    exp = {3'd6, 1'b1, 8'h40, 1'b0};
    checks++;
    if (got !== exp) begin
      $display("FAIL wrap_next_6: got %h expected %h", got, exp);
      errors++;
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    bus.req = 8'h20;
    tick();
    got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
    exp = {3'd5, 1'b1, 8'h20, 1'b0};
    checks++;
    if (got !== exp) begin
      $display("FAIL midrst_grant5: got %h expected %h", got, exp);
      errors++;
    end
    reset   = 1'b1;
    bus.req = 8'h21;
    tick();
    reset = 1'b0;
    got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
    exp = {3'd7, 1'b0, 8'h00, 1'b0};
    checks++;
    if (got !== exp) begin
      $display("FAIL midrst_cleared: got %h expected %h", got, exp);
      errors++;
    end
    tick();
    got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
    exp = {3'd0, 1'b1, 8'h01, 1'b0};
    checks++;
    if (got !== exp) begin
      $display("FAIL midrst_winner0: got %h expected %h", got, exp);
      errors++;
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_hold();
    logic [7:0] eg [0:7];
    logic       et [0:7];
    logic       ev [0:7];
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      eg[c] = (c == 4) ? 8'h00 : 8'h02;
      ev[c] = (c == 4) ? 1'b0 : 1'b1;
      et[c] = (c == 4) ? 1'b1 : 1'b0;
    end
`else
    for (int c = 0; c < 8; c++) begin
      eg[c] = 8'h02;
      ev[c] = 1'b1;
      et[c] = 1'b0;
    end
`endif
    do_reset();
    bus.req = 8'h02;
    for (int c = 0; c < 6; c++) begin
      tick();
      got = {bus.sel, bus.grant_valid, bus.grant, bus.timeout};
      exp = {3'd1, ev[c], eg[c], et[c]};
      checks++;
      if (got !== exp) begin
        $display("FAIL hold_timeout cyc%0d: got %h expected %h", c, got, exp);
        errors++;
      end
    end
    bus.req = 8'h00;
    tick();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    bus.req = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid_busy();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arbitro_rr_8.md
Name: arbitro_rr_8

Overview:
- Round-robin arbiter sharing one 3-bit-selected resource (mux/bus/display slot) among 8 requesters.
- Produces a registered 3-bit select plus a one-hot grant, built by decoding the select and gating it with grant_valid.
- Sits between requesting blocks and the shared datapath; the winner holds ownership until it drops its request.

Parameters:
- MAX_HOLD, 16, max consecutive BUSY cycles before forced release (active only with ARB_TIMEOUT_EN); legal 2..255.
- HOLD_W, 8, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  8  request lines; req[i]=1 means requester i wants or keeps the resource.
- sel  out  3  index of current owner; holds the last owner's value while idle.
- grant_valid  out  1  1 while an owner holds the resource.
- grant  out  8  one-hot owner; equals decode(sel) AND grant_valid; all zero when idle.
- timeout  out  1  one-cycle pulse on forced release; tied 0 when the feature is absent.

Behaviour:
- One clock, clk; reset is synchronous and active-high, sampled on rising clk.
- Reset values: state=IDLE, sel=3'd7 (so the first search starts at 0), grant_valid=0, grant=0, timeout=0, hold counter=0.
- States: IDLE and BUSY. Every output is registered, and sel/grant_valid change only at clock edges.
- IDLE, req==0: stay in IDLE, outputs unchanged.
- IDLE, req!=0:
  - Winner = first i with req[i]=1, scanning (sel+1) mod 8, (sel+2) mod 8, … wrapping to sel itself last.
  - Next edge: sel=winner, grant_valid=1, go to BUSY.
  - Latency from req sampled to grant visible: 1 cycle.
- BUSY, req[sel]=1: stay in BUSY; grant stable; other req bits ignored.
- BUSY, req[sel]=0:
  - Next edge: grant_valid=0, go to IDLE; sel keeps the owner index.
  - At least one dead cycle (grant=0) always separates owners.
  - Earliest new grant is 2 edges after the owner drops req.
- Round-robin fairness: the last owner has lowest priority on the next arbitration. Any requester that holds req high gets a grant within 8 arbitrations.
- Simultaneous events:
  - Owner drops req while others request: release first, arbitrate in the following IDLE cycle.
  - Request arriving in the same cycle as a release is sampled in IDLE on the next cycle.
- Reset mid-BUSY: grant drops to 0 at that edge and the pointer returns to 7. There is no partial handoff.
- Hold counter: cleared on entry to BUSY, increments each BUSY cycle, saturates at MAX_HOLD. It has no effect without the feature.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - In BUSY, when the hold counter reaches MAX_HOLD-1 and req[sel] is still 1, the next edge forces IDLE, clears grant_valid and sets timeout=1 for exactly one cycle.
  - The forced owner becomes lowest priority. If it keeps req high, it re-arbitrates normally.
- Undefined: an owner holds indefinitely, timeout is constant 0, and the counter may be optimized away.

Decomposition:
- Shared package arb_pkg: state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1; NUM_REQ=8; SEL_W=3.
- Sub-module: the one-hot grant decode instantiates the existing decodificador_3bits on sel. Its outputs are ANDed with grant_valid.
- Priority search: a combinational function/block inside arbitro_rr_8, not a separate module.

Test Plan:
- After reset: req=8'h00 for 5 cycles -> grant=0, grant_valid=0, sel=7, timeout=0.
- Single requester and release:
  - req=8'h08 -> next cycle sel=3, grant=8'h08.
  - Hold 4 cycles, then req=0 -> grant=0 one cycle later, sel stays 3.
- Round robin:
  - req=8'hFF held, each owner dropping its bit for exactly one cycle after 2 grant cycles.
  - -> owners in order 0,1,2,…,7,0, each separated by one grant=0 cycle.
- Wrap-around: last owner 6, then req=8'h41 -> winner 0 (scan 7,0); then next with req=8'h41 -> winner 6.
- Reset mid-BUSY: owner 5 granted, reset asserted one cycle with req=8'h21 -> grant=0; after reset, winner is 0 (pointer=7).
- With ARB_TIMEOUT_EN and MAX_HOLD=4:
  - req=8'h02 held -> grant=8'h02 for exactly 4 cycles, then grant=0 with timeout=1 for one cycle, then re-grant of 1.
  - Without the macro, the same stimulus -> grant held throughout and timeout=0.
